path_coord_receiver: RTL and testbench
======================================

// Module: path_coord_receiver
// PURPOSE
//  Consumer end of the pathfinding coordinate handshake (gave_coord/received_coord).
//  Captures each 32-bit packed coord {x[15:0], y[15:0]} into an on-chip buffer and counts entries.
//  Latches end-of-path when the producer pulses finished.
//  Exposes buffer, count and status to the HPS-side register logic through a registered read port.
// PARAMETERS
//  DEPTH  100                   max coords stored per path
//  AW     $clog2(DEPTH)         read address width (derived, do not override)
//  CW     $clog2(DEPTH+1)       count width (derived)
// PORTS
//  clk            in   1    clock
//  reset          in   1    synchronous, active-high reset
//  gave_coord     in   1    producer: coord valid, held until acked
//  coord          in   32   producer data, {x,y}; valid while gave_coord=1
//  path_done      in   1    producer finished pulse (1 cycle)
//  received_coord out  1    ack to producer (4-phase)
//  clear          in   1    host: discard path, re-arm (1-cycle pulse)
//  rd_addr        in   AW   host read index
//  rd_data        out  32   buffer[rd_addr], 1-cycle registered latency
//  count          out  CW   coords stored (saturates at DEPTH)
//  done           out  1    path complete, buffer stable
//  overflow       out  1    >DEPTH coords offered since last clear/reset
// BEHAVIOUR
//  Reset: state=WAIT_COORD; received_coord=0, count=0, done=0, overflow=0, rd_data=0.
//   Buffer contents undefined.
//  FSM states:
//  - WAIT_COORD
//    - gave_coord=1: write coord to buf[count] if count<DEPTH, count+=1.
//      Else drop coord and set overflow=1.
//      received_coord<=1 on the same edge; go to ACK.
//    - path_done=1 (gave_coord=0): done<=1, go to DONE.
//  - ACK
//    - Hold received_coord=1 until gave_coord samples 0.
//    - Then received_coord<=0 on that edge; go to WAIT_COORD, or DONE if done_pending.
//    - Exactly one capture per gave_coord high phase.
//    - A producer low phase of a single cycle must be seen.
//    - Min per-coord turnaround: capture edge, release edge, next capture when gave_coord re-rises.
//  - DONE
//    - gave_coord ignored: no capture, no ack.
//    - Leave only via clear or reset.
//  path_done during ACK: set done_pending; done<=1 on the release edge, then DONE.
//  path_done during WAIT_COORD with gave_coord=1: capture first (go to ACK), treat as above.
//  clear (any state): count<=0, done<=0, overflow<=0, done_pending<=0.
//  - In ACK: stay in ACK with received_coord=1 until gave_coord=0.
//    The in-flight coord is discarded and never re-captured.
//  - Otherwise: go to WAIT_COORD.
//  clear and path_done same cycle: clear wins, path_done ignored.
//  clear and capture same cycle: clear wins, coord not stored; ack proceeds as above.
//  Read port:
//  - rd_data <= buf[rd_addr] every cycle.
//  - rd_addr >= count returns stale/undefined data, not an error.
//  - Reads valid in any state; stable contents guaranteed only when done=1.
//  count: saturates at DEPTH; never wraps.
//  Write addr = count[AW-1:0] only when count<DEPTH.
//  Buffer is single-write/single-read dual-port (M10K-inferable).
//  No read-during-write bypass required.
// TESTING
//  T1 reset then 3 coords (0x00010002, 0x00030004, 0x00050006) with 1-cycle-low producer, then path_done
//     -> count=3, done=1; rd_addr 0..2 returns same values 1 cycle later.
//  T2 hold gave_coord high 10 cycles on one coord
//     -> exactly one capture, count=1, received_coord high until gave_coord drops, low 1 cycle after.
//  T3 offer DEPTH+2 coords
//     -> count=DEPTH, overflow=1, buf[DEPTH-1] = DEPTH-th coord, every offer acked.
//  T4 assert clear while in ACK (count=5)
//     -> count=0, received_coord stays 1 until gave_coord=0, in-flight coord not stored; next coord lands at index 0.
//  T5 path_done same cycle as clear
//     -> done=0, state WAIT_COORD.
//     path_done during ACK -> done=1 on release edge; later gave_coord=1 gets no ack.
//  T6 reset asserted mid-ACK
//     -> received_coord=0, count=0, done=0, overflow=0 next cycle.

Source files
------------

// File: rtl/path_coord_receiver.sv
// Consumer side of the gave_coord/received_coord four-phase handshake. Captures packed
// {x, y} coords into a buffer, counts them, latches end-of-path and offers a
// registered read port to the host.
module path_coord_receiver #(
  parameter int unsigned DEPTH = 100,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gave_coord,
  input  logic [31:0]   coord,
  input  logic          path_done,
  output logic          received_coord,
  input  logic          clear,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          overflow
);

  // Full power-of-two storage so any rd_addr value indexes a real word.
  localparam int unsigned MemDepth = 1 << AW;

  typedef enum logic [1:0] {StWaitCoord, StAck, StDone} state_e;

  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic          pend_q, pend_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          we;
  logic [31:0]   mem [MemDepth];

  // Next-state, handshake and bookkeeping; clear is applied first so it wins everywhere.
  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    count_d    = count_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    pend_d     = pend_q;
    we         = 1'b0;

    if (clear) begin
      count_d    = '0;
      done_d     = 1'b0;
      overflow_d = 1'b0;
      pend_d     = 1'b0;
    end

    unique case (state_q)
      StWaitCoord: begin
        if (gave_coord) begin
          ack_d   = 1'b1;
          state_d = StAck;
          // A coord offered alongside clear is acked but never stored.
          if (!clear) begin
            if (count_q < CW'(DEPTH)) begin
              we      = 1'b1;
              count_d = count_q + CW'(1);
            end else begin
              overflow_d = 1'b1;
            end
            if (path_done) pend_d = 1'b1;
          end
        end else if (path_done && !clear) begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StAck: begin
        if (path_done && !clear) pend_d = 1'b1;
        if (!gave_coord) begin
          ack_d = 1'b0;
          if (pend_d) begin
            done_d  = 1'b1;
            pend_d  = 1'b0;
            state_d = StDone;
          end else begin
            state_d = StWaitCoord;
          end
        end
      end
      StDone: begin
        if (clear) state_d = StWaitCoord;
      end
      default: state_d = StWaitCoord;
    endcase

    rd_data_d = mem[rd_addr];
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StWaitCoord;
      ack_q      <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      pend_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      count_q    <= count_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      pend_q     <= pend_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Coord buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) mem[count_q[AW-1:0]] <= coord;
  end

  assign received_coord = ack_q;
  assign count          = count_q;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_path_coord_receiver.sv
// Bench for path_coord_receiver: directed scenarios with literal expectations plus a
// randomized handshake phase, all checked every cycle against a behavioural model.
module tb_path_coord_receiver;

  localparam int unsigned DEPTH = 100;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          gave_coord = 1'b0;
  logic [31:0]   coord = '0;
  logic          path_done = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          received_coord;
  logic [31:0]   rd_data;
  logic [CW-1:0] count;
  logic          done;
  logic          overflow;

  int n_cmp = 0;
  int n_fail = 0;

  path_coord_receiver #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .gave_coord     (gave_coord),
    .coord          (coord),
    .path_done      (path_done),
    .received_coord (received_coord),
    .clear          (clear),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .count          (count),
    .done           (done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the path as a list of stored coords plus handshake/path flags.
  bit          m_started = 0;
  int          m_count;
  bit          m_done, m_ovf, m_ack;
  bit          m_busy;      // an offered coord has been acked and not yet released
  bit          m_closed;    // path finished, producer ignored
  bit          m_finish_req;
  logic [31:0] m_buf [1 << AW];
  bit          m_valid [1 << AW];
  logic [31:0] m_rd;
  bit          m_rd_chk;

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1; m_count = 0; m_done = 0; m_ovf = 0; m_ack = 0;
      m_busy = 0; m_closed = 0; m_finish_req = 0; m_rd = '0; m_rd_chk = 1;
    end else if (m_started) begin
      bit was_closed;
      m_rd_chk = m_valid[rd_addr];
      m_rd = m_buf[rd_addr];
      was_closed = m_closed;
      if (clear) begin
        m_count = 0; m_done = 0; m_ovf = 0; m_finish_req = 0; m_closed = 0;
      end
      if (was_closed) begin
        // producer ignored
      end else if (!m_busy) begin
        if (gave_coord) begin
          m_ack = 1; m_busy = 1;
          if (!clear) begin
            if (m_count < DEPTH) begin
              m_buf[m_count] = coord; m_valid[m_count] = 1; m_count++;
            end else m_ovf = 1;
            if (path_done) m_finish_req = 1;
          end
        end else if (path_done && !clear) begin
          m_done = 1; m_closed = 1;
        end
      end else begin
        if (path_done && !clear) m_finish_req = 1;
        if (!gave_coord) begin
          m_ack = 0; m_busy = 0;
          if (m_finish_req) begin m_done = 1; m_closed = 1; m_finish_req = 0; end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("received_coord", 32'(received_coord), 32'(m_ack));
      check("count", 32'(count), 32'(m_count));
      check("done", 32'(done), 32'(m_done));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_rd_chk) check("rd_data", rd_data, m_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ack(input logic val);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (received_coord === val) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL ack_timeout: received_coord never reached %0b at %0t", val, $time);
  endtask

  // Offer one coord; returns with gave_coord low and ack released (1-cycle low phase next).
  task automatic offer(input logic [31:0] c);
    gave_coord = 1'b1;
    coord = c;
    wait_ack(1'b1);
    gave_coord = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic read_chk(input string name, input int addr, input logic [31:0] exp);
    rd_addr = AW'(addr);
    step();
    step();
    check(name, rd_data, exp);
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;

    // T1: three coords with 1-cycle-low producer, then path_done.
    offer(32'h0001_0002);
    offer(32'h0003_0004);
    offer(32'h0005_0006);
    path_done = 1'b1;
    step();
    path_done = 1'b0;
    check("t1_count", 32'(count), 32'd3);
    check("t1_done", 32'(done), 32'd1);
    read_chk("t1_rd0", 0, 32'h0001_0002);
    read_chk("t1_rd1", 1, 32'h0003_0004);
    read_chk("t1_rd2", 2, 32'h0005_0006);

    // T2: gave_coord held high 10 cycles -> one capture.
    pulse_clear();
    gave_coord = 1'b1;
    coord = 32'hA5A5_0001;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_ack_hold", 32'(received_coord), 32'd1);
    end
    gave_coord = 1'b0;
    step();
    check("t2_ack_rel", 32'(received_coord), 32'd0);
    check("t2_count", 32'(count), 32'd1);

    // T3: DEPTH+2 offers -> saturation and overflow.
    pulse_clear();
    for (int i = 0; i < DEPTH + 2; i++) offer(32'(i + 1));
    check("t3_count", 32'(count), 32'(DEPTH));
    check("t3_ovf", 32'(overflow), 32'd1);
    read_chk("t3_last", DEPTH - 1, 32'(DEPTH));

    // T4: clear while in ACK with count=5.
    pulse_clear();
    for (int i = 0; i < 5; i++) offer(32'h0700_0000 + 32'(i));
    gave_coord = 1'b1;
    coord = 32'hDEAD_BEEF;
    wait_ack(1'b1);
    pulse_clear();
    check("t4_ack_held", 32'(received_coord), 32'd1);
    check("t4_count", 32'(count), 32'd0);
    gave_coord = 1'b0;
    wait_ack(1'b0);
    offer(32'h0000_1234);
    check("t4_count1", 32'(count), 32'd1);
    read_chk("t4_idx0", 0, 32'h0000_1234);

    // T5: path_done with clear is ignored; path_done during ACK completes on release.
    clear = 1'b1;
    path_done = 1'b1;
    step();
    clear = 1'b0;
    path_done = 1'b0;
    check("t5_done_clr", 32'(done), 32'd0);
    offer(32'h0000_0055);
    gave_coord = 1'b1;
    coord = 32'h0000_0066;
    wait_ack(1'b1);
    path_done = 1'b1;
    step();
    path_done = 1'b0;
    check("t5_pending", 32'(done), 32'd0);
    gave_coord = 1'b0;
    step();
    check("t5_done", 32'(done), 32'd1);
    check("t5_ack_rel", 32'(received_coord), 32'd0);
    gave_coord = 1'b1;
    repeat (5) begin
      step();
      check("t5_no_ack", 32'(received_coord), 32'd0);
    end
    gave_coord = 1'b0;

    // T6: reset in the middle of ACK.
    pulse_clear();
    offer(32'h0000_0077);
    gave_coord = 1'b1;
    wait_ack(1'b1);
    reset = 1'b1;
    step();
    check("t6_ack", 32'(received_coord), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    gave_coord = 1'b0;
    step();

    // Randomized producer obeying the four-phase protocol, random host activity.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (gave_coord && received_coord) begin
        if ($urandom_range(1, 0) == 1) gave_coord = 1'b0;
      end else if (!gave_coord && !received_coord) begin
        if ($urandom_range(1, 0) == 1) begin
          gave_coord = 1'b1;
          coord = $urandom;
        end
      end
      clear = ($urandom_range(399, 0) == 0);
      path_done = ($urandom_range(199, 0) == 0);
      reset = ($urandom_range(999, 0) == 0);
      rd_addr = AW'($urandom_range((1 << AW) - 1, 0));
      step();
    end
    clear = 1'b0;
    path_done = 1'b0;
    reset = 1'b0;
    gave_coord = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
